// File: rtl/byte_serial_tx_pkg.sv
// byte_serial_tx_pkg: state encoding and line levels shared by the serial transmitter
package byte_serial_tx_pkg;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
endpackage

// File: rtl/byte_serial_tx_bit_timer.sv
// byte_serial_tx_bit_timer: one-cycle tick every CLKS_PER_BIT cycles, held at zero while clr_i
module byte_serial_tx_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tick_o
);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  assign tick_o = cnt_q == CW'(CLKS_PER_BIT - 1);
  assign cnt_d  = (clr_i || tick_o) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
endmodule

// File: rtl/byte_serial_tx.sv
// byte_serial_tx: start bit, LSB-first data, optional even parity, stop bit on txd
module byte_serial_tx
  import byte_serial_tx_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 0
) (
  input  logic              clk,
  input  logic              R,
  input  logic [DATA_W-1:0] D,
  input  logic              E,
  output logic              ready,
  output logic              busy,
  output logic              txd,
  output logic [DATA_W-1:0] Q,
  output logic              done
);
  localparam int IW = DATA_W > 1 ? $clog2(DATA_W) : 1;
  state_t            st_q, st_d;
  logic [DATA_W-1:0] sr_q, sr_d, q_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              txd_d, par_q, par_d, done_d;
  logic              tick, accept, last;
  assign ready  = st_q == S_IDLE;
  assign busy   = ~ready;
  assign accept = E && ready;
  assign last   = idx_q == IW'(DATA_W - 1);
  byte_serial_tx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk    (clk),
    .rst    (R),
    .clr_i  (ready),
    .tick_o (tick)
  );
  always_ff @(posedge clk or posedge R)
    if (R) st_q <= S_IDLE;
    else   st_q <= st_d;
  always_comb begin
    st_d = st_q;
    case (st_q)
      S_IDLE:   st_d = accept ? S_START : S_IDLE;
      S_START:  st_d = tick ? S_DATA : S_START;
      S_DATA:   st_d = (tick && last) ? (PARITY_EN != 0 ? S_PARITY : S_STOP) : S_DATA;
      S_PARITY: st_d = tick ? S_STOP : S_PARITY;
      S_STOP:   st_d = tick ? S_IDLE : S_STOP;
      default:  st_d = S_IDLE;
    endcase
  end
  // txd carries the value for the bit that begins at the next edge
  always_comb begin
    txd_d  = txd;
    sr_d   = sr_q;
    idx_d  = idx_q;
    q_d    = Q;
    par_d  = par_q;
    done_d = 1'b0;
    if (accept) begin
      q_d   = D;
      sr_d  = D;
      par_d = ^D;
      idx_d = '0;
      txd_d = START_BIT;
    end else if (tick) begin
      if (st_q == S_START || (st_q == S_DATA && !last)) begin
        txd_d = sr_q[0];
        sr_d  = sr_q >> 1;
        idx_d = st_q == S_DATA ? idx_q + 1'b1 : idx_q;
      end else if (st_q == S_DATA) begin
        txd_d = PARITY_EN != 0 ? par_q : STOP_BIT;
      end else if (st_q == S_PARITY) begin
        txd_d = STOP_BIT;
      end else if (st_q == S_STOP) begin
        txd_d  = LINE_IDLE;
        done_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge R)
    if (R) begin
      txd   <= LINE_IDLE;
      sr_q  <= '0;
      idx_q <= '0;
      Q     <= '0;
      par_q <= 1'b0;
      done  <= 1'b0;
    end else begin
      txd   <= txd_d;
      sr_q  <= sr_d;
      idx_q <= idx_d;
      Q     <= q_d;
      par_q <= par_d;
      done  <= done_d;
    end
endmodule

// File: doc/byte_serial_tx.md
Name: byte_serial_tx

Overview:
Parallel-to-serial byte transmitter that takes an 8-bit word on the same D/E interface our 8-bit enable/reset register uses, and shifts it out on a single line.
- Frame format: one start bit (0), DATA_W data bits LSB first, an optional even-parity bit, and one stop bit (1).
- Sits between the register bank and the board serial pin.
- Pairs with the register as its transmit-side counterpart.

Parameters:
DATA_W, 8, data word width in bits
CLKS_PER_BIT, 4, clock cycles per serial bit (legal range 1..255)
PARITY_EN, 0, 1 = insert even-parity bit after the data bits; 0 = no parity bit

Ports:
clk  input  1  system clock, rising edge
R  input  1  reset, asynchronous, active-high
D  input  DATA_W  byte to transmit
E  input  1  load strobe; byte accepted when E=1 and ready=1 at a rising clk edge
ready  output  1  1 = idle, can accept a byte
busy  output  1  1 = frame in progress; always the inverse of ready
txd  output  1  serial line, idles high
Q  output  DATA_W  copy of the byte most recently accepted
done  output  1  one-cycle pulse when a frame completes

Behaviour:
- Reset (R=1, asynchronous, any time including mid-frame):
  - State goes to IDLE, txd=1, ready=1, busy=0, done=0, Q=0.
  - All counters clear.
  - The frame is abandoned; no partial stop bit is sent.
- FSM states and transitions:
  - IDLE: go to START when the byte is accepted.
  - START: go to DATA after CLKS_PER_BIT cycles.
  - DATA: go to PARITY when PARITY_EN=1, otherwise to STOP, after DATA_W bit periods.
  - PARITY: go to STOP after one bit period.
  - STOP: go to IDLE after one bit period.
- Accept:
  - At the edge where E=1 and ready=1: Q<=D, shift register<=D, state<=START, txd<=0 (registered).
  - txd is therefore low from the cycle after acceptance.
- Bit timing:
  - Each bit is held on txd for exactly CLKS_PER_BIT cycles.
  - Bit-cycle counter runs 0..CLKS_PER_BIT-1; a bit advances when the counter wraps.
  - Bit index counter runs 0..DATA_W-1.
- Data order: bit 0 first; the shift register shifts right on each data-bit advance.
- Parity bit = XOR of the accepted byte (even parity across data plus parity bit).
- Frame length: (DATA_W+2+PARITY_EN)*CLKS_PER_BIT cycles with txd driven by the frame.
- Completion:
  - The cycle after the last STOP cycle: state=IDLE, ready=1, done=1 for exactly one cycle.
  - done=0 in all other cycles.
- Back-to-back: E=1 during the done cycle is accepted. Minimum spacing between accept edges is frame length + 1 cycle.
- E while busy: ignored, with no effect on Q or the frame in flight. D may change freely once accepted.
- E held high continuously: a new frame is accepted every frame length + 1 cycles.
- CLKS_PER_BIT=1: the counter is degenerate; every bit lasts one cycle.
- All outputs are registered except ready and busy, which decode directly from the state register.

Decomposition:
- Shared package holds:
  - State encoding constants S_IDLE=0, S_START=1, S_DATA=2, S_PARITY=3, S_STOP=4 (3-bit).
  - Line-level constants LINE_IDLE=1, START_BIT=0, STOP_BIT=1.
- One sub-module is natural: bit_timer. It is a CLKS_PER_BIT tick generator with a clear input and a one-cycle tick output, driven by the same clk/R.

Test Plan:
- Reset check: R=1 pulsed asynchronously between clock edges → txd=1, ready=1, busy=0, done=0, Q=00000000 immediately, without waiting for an edge.
- Single frame: D=10100101, E=1 for one cycle, CLKS_PER_BIT=4, PARITY_EN=0 →
  - Q=10100101.
  - txd sequence, 4 cycles per bit: 0,1,0,1,0,0,1,0,1,1.
  - busy high for 40 cycles; done pulses on cycle 41 with ready=1.
- Parity: PARITY_EN=1, D=00000111 → parity bit=1; frame is 11 bits (44 cycles). D=00000011 → parity bit=0.
- Ignore while busy: accept D=11110000, then drive D=00001111 with E=1 mid-frame → Q stays 11110000; serial data is 0,0,0,0,1,1,1,1; no second frame starts before done.
- Back-to-back: E held at 1, D=00000001 then D=10000000 presented at the done cycle → second start bit begins the cycle after done; spacing is 41 cycles between accepts.
- Reset mid-frame: R=1 during DATA bit 3 of D=11111111 → txd=1 at once, ready=1; a new byte with E=1 after R=0 produces a full correct frame.
